// File: rtl/softusb_pmem_loader_if.sv
// Host-side command, word-stream and status bus of the navre program-memory loader.
// The host is the master; the loader is the slave.
interface softusb_pmem_loader_if #(
   parameter int pmem_width = 12
);
   logic                  cmd_load;
   logic                  cmd_run;
   logic                  cmd_halt;
   logic [pmem_width-1:0] load_base;
   logic [pmem_width:0]   load_count;
   logic                  wr_stb;
   logic [15:0]           wr_dat;
   logic                  wr_ack;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [15:0]           sum;

   modport master (
      output cmd_load, cmd_run, cmd_halt, load_base, load_count, wr_stb, wr_dat,
      input  wr_ack, busy, done, err, sum
   );

   modport slave (
      input  cmd_load, cmd_run, cmd_halt, load_base, load_count, wr_stb, wr_dat,
      output wr_ack, busy, done, err, sum
   );
endinterface

// File: rtl/softusb_pmem_loader.sv
// Owns the navre core reset and the program-memory port: streams host words into
// pmem while the core is halted and passes the core's fetch port through while it runs.
module softusb_pmem_loader #(
   parameter int pmem_width = 12
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   softusb_pmem_loader_if.slave  host,
   input  logic                  cpu_pmem_ce,
   input  logic [pmem_width-1:0] cpu_pmem_a,
   output logic                  pmem_ce,
   output logic                  pmem_we,
   output logic [pmem_width-1:0] pmem_a,
   output logic [15:0]           pmem_d,
   output logic                  core_rst
);
   typedef enum logic [1:0] {
      ST_HALT = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [pmem_width+1:0] PMEM_DEPTH = {2'b01, {pmem_width{1'b0}}};

   state_t                state_r;
   state_t                next_state_s;
   logic                  core_rst_r;
   logic                  we_r;
   logic [pmem_width-1:0] a_r;
   logic [15:0]           d_r;
   logic [pmem_width-1:0] ptr_r;
   logic [pmem_width:0]   rem_r;
   logic                  done_r;
   logic                  err_r;
   logic [15:0]           sum_r;
   logic [pmem_width+1:0] load_end_s;
   logic                  ovf_s;
   logic                  accept_load_s;
   logic                  wr_ack_s;

   // Command decode, overflow check and next-state selection (halt > load > run).
   always_comb begin
      next_state_s  = state_r;
      load_end_s    = {2'b00, host.load_base} + {1'b0, host.load_count};
      ovf_s         = (load_end_s > PMEM_DEPTH);
      accept_load_s = 1'b0;
      wr_ack_s      = 1'b0;
      case (state_r)
         ST_HALT: begin
            if (host.cmd_halt) begin
               next_state_s = ST_HALT;
            end else if (host.cmd_load) begin
               accept_load_s = 1'b1;
               if (ovf_s || (host.load_count == {(pmem_width+1){1'b0}})) begin
                  next_state_s = ST_HALT;
               end else begin
                  next_state_s = ST_LOAD;
               end
            end else if (host.cmd_run) begin
               next_state_s = ST_RUN;
            end else begin
               next_state_s = ST_HALT;
            end
         end
         ST_LOAD: begin
            if (host.cmd_halt) begin
               next_state_s = ST_HALT;
            end else begin
               wr_ack_s = host.wr_stb;
               if (host.wr_stb && (rem_r == {{pmem_width{1'b0}}, 1'b1})) begin
                  next_state_s = ST_HALT;
               end else begin
                  next_state_s = ST_LOAD;
               end
            end
         end
         ST_RUN: begin
            if (host.cmd_halt) begin
               next_state_s = ST_HALT;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         default: begin
            next_state_s = ST_HALT;
         end
      endcase
   end

   // State, registered core reset, loader write stage and status flags.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r    <= ST_HALT;
         core_rst_r <= 1'b1;
         we_r       <= 1'b0;
         a_r        <= {pmem_width{1'b0}};
         d_r        <= 16'h0000;
         ptr_r      <= {pmem_width{1'b0}};
         rem_r      <= {(pmem_width+1){1'b0}};
         done_r     <= 1'b0;
         err_r      <= 1'b0;
         sum_r      <= 16'h0000;
      end else begin
         state_r    <= next_state_s;
         core_rst_r <= (next_state_s != ST_RUN);
         we_r       <= 1'b0;
         if (accept_load_s) begin
            sum_r  <= 16'h0000;
            err_r  <= ovf_s;
            done_r <= !ovf_s && (host.load_count == {(pmem_width+1){1'b0}});
            if (next_state_s == ST_LOAD) begin
               ptr_r <= host.load_base;
               rem_r <= host.load_count;
            end
         end else if ((state_r == ST_LOAD) && host.cmd_halt) begin
            // Abort: any write registered last cycle still drains from we_r.
            done_r <= 1'b0;
            err_r  <= 1'b0;
         end else if (wr_ack_s) begin
            we_r  <= 1'b1;
            a_r   <= ptr_r;
            d_r   <= host.wr_dat;
            ptr_r <= ptr_r + {{(pmem_width-1){1'b0}}, 1'b1};
            rem_r <= rem_r - {{pmem_width{1'b0}}, 1'b1};
            sum_r <= sum_r + host.wr_dat;
            if (rem_r == {{pmem_width{1'b0}}, 1'b1}) begin
               done_r <= 1'b1;
            end
         end
      end
   end

   // The core fetch path is combinational so the core sees plain synchronous-RAM timing.
   assign pmem_ce     = (state_r == ST_RUN) ? cpu_pmem_ce : we_r;
   assign pmem_we     = (state_r == ST_RUN) ? 1'b0 : we_r;
   assign pmem_a      = (state_r == ST_RUN) ? cpu_pmem_a : a_r;
   assign pmem_d      = d_r;
   assign core_rst    = core_rst_r;
   assign host.wr_ack = wr_ack_s;
   assign host.busy   = (state_r == ST_LOAD);
   assign host.done   = done_r;
   assign host.err    = err_r;
   assign host.sum    = sum_r;
endmodule

// File: doc/softusb_pmem_loader.md
# softusb_pmem_loader

Program-memory loader and access controller for the softusb navre microcontroller. It owns the navre core's reset and the single port of the 16-bit program memory. While the core is halted, it streams host-supplied instruction words into pmem at a programmed base address and keeps a running checksum. While the core runs, it passes the core's instruction-fetch port straight through to pmem.

## Interface
Parameters:
- pmem_width, 12, pmem word-address width (pmem depth = 2^pmem_width words)

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge
- sys_rst  in  1  synchronous, active-high reset
- cmd_load  in  1  pulse: start a load of load_count words at load_base
- cmd_run  in  1  pulse: release the core from reset
- cmd_halt  in  1  pulse: put the core in reset, or abort a load
- load_base  in  pmem_width  first word address; sampled on accepted cmd_load
- load_count  in  pmem_width+1  number of words; sampled on accepted cmd_load
- wr_stb  in  1  host word valid
- wr_dat  in  16  host instruction word
- wr_ack  out  1  word accepted this cycle (combinational)
- cpu_pmem_ce  in  1  core fetch enable
- cpu_pmem_a  in  pmem_width  core fetch address
- pmem_ce  out  1  pmem enable
- pmem_we  out  1  pmem write enable
- pmem_a  out  pmem_width  pmem address
- pmem_d  out  16  pmem write data
- core_rst  out  1  navre reset (registered)
- busy  out  1  state == LOAD
- done  out  1  last load completed (sticky until next cmd_load)
- err  out  1  last cmd_load was rejected (sticky until next cmd_load)
- sum  out  16  modulo-2^16 sum of words accepted since last cmd_load

## Operation
- States: HALT (reset state), LOAD, RUN.
- Reset values:
  - state = HALT; core_rst = 1.
  - pmem_we = pmem_ce = 0; pmem_a = 0; pmem_d = 0.
  - done = err = 0; sum = 0.
  - Internal pointer ptr = 0; remaining = 0.
- Command priority when pulses coincide: cmd_halt > cmd_load > cmd_run.
- HALT, on cmd_load:
  - Clear sum, done and err in every case.
  - If load_base + load_count > 2^pmem_width (evaluated at pmem_width+1 bits plus carry): set err = 1 and stay in HALT.
  - Else if load_count == 0: set done = 1 and stay in HALT.
  - Otherwise: ptr <= load_base, remaining <= load_count, go to LOAD.
- HALT, on cmd_run: go to RUN.
- LOAD:
  - wr_ack = wr_stb whenever state == LOAD and no cmd_halt is present; wr_ack = 0 in all other states.
  - On each accepted word:
    - Next cycle drives pmem_we = pmem_ce = 1, pmem_a = ptr, pmem_d = wr_dat.
    - ptr increments; remaining decrements; sum += wr_dat.
  - When remaining goes 1 -> 0: go to HALT and set done = 1.
  - cmd_run and cmd_load are ignored in LOAD.
  - cmd_halt aborts: go to HALT with done = 0 and err = 0. A write already registered still completes; written words are not rolled back.
- RUN:
  - core_rst = 0.
  - pmem_ce = cpu_pmem_ce and pmem_a = cpu_pmem_a, passed through combinationally; pmem_we = 0.
  - cmd_load is ignored (no flag change).
  - cmd_halt goes to HALT.
- In HALT and LOAD, outside write cycles: pmem_ce = pmem_we = 0; pmem_a holds its last loader value.
- ptr never wraps, because the overflow check rejects any load that would cross the top of pmem.

## Timing
- core_rst is registered:
  - cmd_run sampled at edge N gives core_rst = 0 after edge N.
  - cmd_halt sampled at edge N gives core_rst = 1 after edge N, and the pass-through is removed in the same cycle.
- Write latency: a word accepted at edge N appears on pmem_we/a/d during cycle N+1 and is written into pmem at edge N+1.
- Throughput is one word per cycle with wr_stb held high; there are no bubbles.
- busy falls, and done rises, in the cycle after the edge that accepted the last word. That is the same cycle in which the last pmem write is driven.
- sum and done are stable from that cycle on.
- Fetch pass-through adds zero latency, so the core sees the normal one-cycle synchronous-RAM read.
- sys_rst mid-load: every register returns to its reset value at the next edge. An in-flight write is dropped if sys_rst is sampled at the edge that would have registered it.

## Test plan
- Load 4 words 0x1111, 0x2222, 0x3333, 0x4444 at base 0x010, wr_stb held high -> wr_ack high for 4 cycles; pmem[0x010..0x013] hold those values; sum = 0xAAAA; done = 1, busy = 0, core_rst still 1.
- load_base = 0xFFE, load_count = 3 (pmem_width = 12) -> err = 1, state stays HALT, no pmem_we pulse. Then base 0xFFE, count 2 -> done = 1 with pmem[0xFFE], pmem[0xFFF] written.
- load_count = 0 -> done = 1 the next cycle, busy never asserts, sum = 0.
- Load 8 words with cmd_halt pulsed after the 3rd accept -> exactly 3 writes occur; wr_ack = 0 in the halt cycle; done = 0, err = 0; HALT.
- cmd_run -> core_rst = 0 the next cycle; cpu_pmem_a = 0x123 with cpu_pmem_ce = 1 appears on pmem_a/pmem_ce the same cycle; cmd_load in RUN has no effect; cmd_halt -> core_rst = 1 the next cycle.
- cmd_halt and cmd_run pulsed together in RUN -> HALT wins; core_rst = 1.
